red_pitaya_asg_ch_seq: RTL and testbench

- Next-generation ASG channel: one waveform table split into up to NSEG independently configured segments, played as a linked sequence.
- Generalises the two-buffer ping-pong channel to N segments with explicit next-segment links and a stop-on-last flag.
- Adds parametrised DAC/table width and a programmable inter-segment gap.
- Sits between the ASG register bank (configuration, table writes) and the DAC output mux.

---
 rtl/red_pitaya_asg_ch_seq_if.sv | 24 ++
 rtl/red_pitaya_asg_ch_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_red_pitaya_asg_ch_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/red_pitaya_asg_ch_seq_if.sv
// ---------------------------------------------------------------------------
// red_pitaya_asg_ch_seq_if
//   Waveform-table access bus between the ASG register bank and one
//   sequenced channel.
//   buf_we_i     : table write enable
//   buf_addr_i   : shared write / read-back address
//   buf_wdata_i  : table write data
//   buf_rdata_o  : table read-back data, one cycle after the address
//   master = register bank side, slave = channel side.
// ---------------------------------------------------------------------------
interface red_pitaya_asg_ch_seq_if #(
    parameter int RSZ = 14,
    parameter int DW  = 14
);
    logic           buf_we_i;
    logic [RSZ-1:0] buf_addr_i;
    logic [DW-1:0]  buf_wdata_i;
    logic [DW-1:0]  buf_rdata_o;

    modport master (output buf_we_i, output buf_addr_i, output buf_wdata_i,
                    input  buf_rdata_o);
    modport slave  (input  buf_we_i, input  buf_addr_i, input  buf_wdata_i,
                    output buf_rdata_o);
endinterface

// File: rtl/red_pitaya_asg_ch_seq.sv
// ---------------------------------------------------------------------------
// red_pitaya_asg_ch_seq
//   Sequenced ASG channel. One waveform table is split into NSEG segments,
//   each with its own start/size/step/period count/amplitude/offset, and the
//   segments are played as a linked list (next index + last flag), with an
//   optional idle gap between segments.
//
//   dac_clk_i / dac_rstn_i : clock, async active-low reset
//   dac_o                  : scaled, offset, saturated sample
//   trig_sw_i/ext_i/src_i  : trigger inputs and source select
//   trig_done_o            : one-cycle pulse at sequence end
//   seg_o / busy_o         : active segment, RUN-or-GAP flag
//   buf_if                 : table write / read-back bus
//   buf_rpnt_o             : integer part of the read pointer
//   set_*                  : per-segment (packed, segment 0 in the LSBs)
//                            and global configuration
// ---------------------------------------------------------------------------
module red_pitaya_asg_ch_seq #(
    parameter int RSZ  = 14,
    parameter int DW   = 14,
    parameter int NSEG = 4,
    parameter int SW   = 2
) (
    input  logic                     dac_clk_i,
    input  logic                     dac_rstn_i,
    output logic [DW-1:0]            dac_o,
    input  logic                     trig_sw_i,
    input  logic                     trig_ext_i,
    input  logic [1:0]               trig_src_i,
    output logic                     trig_done_o,
    output logic [SW-1:0]            seg_o,
    output logic                     busy_o,
    red_pitaya_asg_ch_seq_if.slave   buf_if,
    output logic [RSZ-1:0]           buf_rpnt_o,
    input  logic [NSEG*DW-1:0]       set_amp_i,
    input  logic [NSEG*DW-1:0]       set_dc_i,
    input  logic [NSEG*(RSZ+16)-1:0] set_ofs_i,
    input  logic [NSEG*(RSZ+16)-1:0] set_size_i,
    input  logic [NSEG*(RSZ+16)-1:0] set_step_i,
    input  logic [NSEG*16-1:0]       set_ncyc_i,
    input  logic [NSEG*SW-1:0]       set_next_i,
    input  logic [NSEG-1:0]          set_last_i,
    input  logic [SW-1:0]            set_first_i,
    input  logic [31:0]              set_gap_i,
    input  logic                     set_rst_i,
    input  logic                     set_zero_i
);
    localparam int PW = RSZ + 16;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

    // ---------------- per-segment field slices ----------------
    logic [PW-1:0] w_ofs  [NSEG];
    logic [PW-1:0] w_size [NSEG];
    logic [PW-1:0] w_step [NSEG];
    logic [15:0]   w_ncyc [NSEG];
    logic [SW-1:0] w_next [NSEG];
    logic [DW-1:0] w_amp  [NSEG];
    logic [DW-1:0] w_dc   [NSEG];

    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        assign w_ofs[g]  = set_ofs_i [g*PW +: PW];
        assign w_size[g] = set_size_i[g*PW +: PW];
        assign w_step[g] = set_step_i[g*PW +: PW];
        assign w_ncyc[g] = set_ncyc_i[g*16 +: 16];
        assign w_next[g] = set_next_i[g*SW +: SW];
        assign w_amp[g]  = set_amp_i [g*DW +: DW];
        assign w_dc[g]   = set_dc_i  [g*DW +: DW];
    end

    // ---------------- sequencer ----------------
    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_ptr,   w_ptr_nxt;
    logic [SW-1:0] r_seg,   w_seg_nxt;
    logic [15:0]   r_cyc,   w_cyc_nxt;
    logic [31:0]   r_gcnt,  w_gcnt_nxt;
    logic          r_trig;
    logic          w_trig;
    logic [PW:0]   w_npnt;
    logic          w_pend;
    logic [SW-1:0] w_nidx;

    assign w_trig = (trig_src_i[0] & trig_sw_i) | (trig_src_i[1] & trig_ext_i);
    assign w_nidx = w_next[r_seg];
    // One extra bit so a step past the top of the table still wraps cleanly.
    assign w_npnt = {1'b0, r_ptr} + {1'b0, w_step[r_seg]};
    assign w_pend = w_npnt > {1'b0, w_size[r_seg]};

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_seg_nxt   = r_seg;
        w_cyc_nxt   = r_cyc;
        w_gcnt_nxt  = r_gcnt;
        if (set_rst_i) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = w_ofs[set_first_i];
            w_seg_nxt   = set_first_i;
            w_cyc_nxt   = '0;
            w_gcnt_nxt  = '0;
        end else begin
            unique case (r_state)
                S_IDLE: if (r_trig) begin
                    w_state_nxt = S_RUN;
                    w_seg_nxt   = set_first_i;
                    w_ptr_nxt   = w_ofs[set_first_i];
                    w_cyc_nxt   = w_ncyc[set_first_i];
                end
                S_RUN: begin
                    if (!w_pend) begin
                        w_ptr_nxt = w_npnt[PW-1:0];
                    end else if (r_cyc == 16'd1) begin
                        // Segment end: the pointer stays on the last sample
                        // so DONE/GAP hold the final output value.
                        if (set_last_i[r_seg]) begin
                            w_state_nxt = S_DONE;
                        end else if (set_gap_i == 32'd0) begin
                            w_seg_nxt = w_nidx;
                            w_ptr_nxt = w_ofs[w_nidx];
                            w_cyc_nxt = w_ncyc[w_nidx];
                        end else begin
                            w_state_nxt = S_GAP;
                            w_gcnt_nxt  = '0;
                        end
                    end else begin
                        w_ptr_nxt = w_ofs[r_seg];
                        if (r_cyc != 16'd0) w_cyc_nxt = r_cyc - 16'd1;
                    end
                end
                S_GAP: begin
                    // >= rather than == so a gap shortened mid-wait still exits
                    if (r_gcnt + 32'd1 >= set_gap_i) begin
                        w_state_nxt = S_RUN;
                        w_seg_nxt   = w_nidx;
                        w_ptr_nxt   = w_ofs[w_nidx];
                        w_cyc_nxt   = w_ncyc[w_nidx];
                    end else begin
                        w_gcnt_nxt = r_gcnt + 32'd1;
                    end
                end
                S_DONE: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_seg   <= '0;
            r_cyc   <= '0;
            r_gcnt  <= '0;
            r_trig  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_seg   <= w_seg_nxt;
            r_cyc   <= w_cyc_nxt;
            r_gcnt  <= w_gcnt_nxt;
            // A trigger arriving with set_rst_i is dropped, not deferred.
            r_trig  <= w_trig & ~set_rst_i;
        end
    end

    assign trig_done_o = (r_state == S_DONE);
    assign busy_o      = (r_state == S_RUN) || (r_state == S_GAP);
    assign seg_o       = r_seg;
    assign buf_rpnt_o  = r_ptr[PW-1:16];

    // ---------------- table ----------------
    logic [DW-1:0] r_mem [2**RSZ];

    always_ff @(posedge dac_clk_i) begin
        if (buf_if.buf_we_i) r_mem[buf_if.buf_addr_i] <= buf_if.buf_wdata_i;
    end

    // ---------------- read / scale pipeline ----------------
    // r_seg_pipe[k] is the segment of the sample k stages behind the pointer.
    logic [4:1][SW-1:0]  r_seg_pipe;
    logic [RSZ-1:0]      r_addr;
    logic [DW-1:0]       r_ram, r_data, r_rdata;
    logic [DW:0]         r_mult;
    logic [DW+1:0]       r_sum;
    logic [DW-1:0]       r_dac;
    logic signed [2*DW:0] w_prod;
    logic [DW+1:0]       w_sum;
    logic [DW-1:0]       w_sat;
    logic [DW-1:0]       w_dc_sel;
    logic                w_unused_prod;

    assign w_prod = $signed(r_data) * $signed({1'b0, w_amp[r_seg_pipe[3]]});
    assign w_unused_prod = &{1'b0, w_prod[2*DW], w_prod[DW-2:0]};
    assign w_dc_sel = w_dc[r_seg_pipe[4]];
    // Two guard bits: a full-scale product plus a full-scale offset needs
    // DW+2 bits, otherwise the sum wraps and saturates the wrong way.
    assign w_sum = {r_mult[DW], r_mult} + {{2{w_dc_sel[DW-1]}}, w_dc_sel};

    always_comb begin
        w_sat = r_sum[DW-1:0];
        if (!r_sum[DW+1] && (r_sum[DW] || r_sum[DW-1]))
            w_sat = {1'b0, {(DW-1){1'b1}}};
        else if (r_sum[DW+1] && !(r_sum[DW] && r_sum[DW-1]))
            w_sat = {1'b1, {(DW-1){1'b0}}};
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            r_seg_pipe <= '0;
            r_addr     <= '0;
            r_ram      <= '0;
            r_rdata    <= '0;
            r_data     <= '0;
            r_mult     <= '0;
            r_sum      <= '0;
            r_dac      <= '0;
        end else begin
            r_seg_pipe <= {r_seg_pipe[3:1], r_seg};
            r_addr     <= r_ptr[PW-1:16];
            // Write-first: a write to the played address is seen immediately.
            r_ram      <= (buf_if.buf_we_i && buf_if.buf_addr_i == r_addr) ?
                          buf_if.buf_wdata_i : r_mem[r_addr];
            r_rdata    <= buf_if.buf_we_i ? buf_if.buf_wdata_i : r_mem[buf_if.buf_addr_i];
            r_data     <= r_ram;
            r_mult     <= w_prod[2*DW-1:DW-1];
            r_sum      <= w_sum;
            r_dac      <= set_zero_i ? '0 : w_sat;
        end
    end

    assign dac_o              = r_dac;
    assign buf_if.buf_rdata_o = r_rdata;

endmodule

// File: tb/tb_red_pitaya_asg_ch_seq.sv
module tb_red_pitaya_asg_ch_seq;
    localparam int RSZ = 14, DW = 14, NSEG = 4, SW = 2, PW = RSZ + 16;

    logic clk = 1'b0, rstn = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]        dac_o;
    logic                 trig_sw = 0, trig_ext = 0, done, busy;
    logic [1:0]           trig_src = 2'd1;
    logic [SW-1:0]        seg_o;
    logic [RSZ-1:0]       rpnt;
    logic [NSEG*DW-1:0]   set_amp = '0, set_dc = '0;
    logic [NSEG*PW-1:0]   set_ofs = '0, set_size = '0, set_step = '0;
    logic [NSEG*16-1:0]   set_ncyc = '0;
    logic [NSEG*SW-1:0]   set_next = '0;
    logic [NSEG-1:0]      set_last = '0;
    logic [SW-1:0]        set_first = '0;
    logic [31:0]          set_gap = '0;
    logic                 set_rst = 0, set_zero = 0;

    red_pitaya_asg_ch_seq_if #(.RSZ(RSZ), .DW(DW)) bif ();

    red_pitaya_asg_ch_seq #(.RSZ(RSZ), .DW(DW), .NSEG(NSEG), .SW(SW)) dut (
        .dac_clk_i(clk), .dac_rstn_i(rstn), .dac_o(dac_o),
        .trig_sw_i(trig_sw), .trig_ext_i(trig_ext), .trig_src_i(trig_src),
        .trig_done_o(done), .seg_o(seg_o), .busy_o(busy),
        .buf_if(bif.slave), .buf_rpnt_o(rpnt),
        .set_amp_i(set_amp), .set_dc_i(set_dc), .set_ofs_i(set_ofs),
        .set_size_i(set_size), .set_step_i(set_step), .set_ncyc_i(set_ncyc),
        .set_next_i(set_next), .set_last_i(set_last), .set_first_i(set_first),
        .set_gap_i(set_gap), .set_rst_i(set_rst), .set_zero_i(set_zero)
    );

    int npass = 0, ntot = 0;
    logic [DW-1:0]  q[$];
    logic           tr_done [0:63];
    logic           tr_busy [0:63];
    logic [SW-1:0]  tr_seg  [0:63];
    logic [RSZ-1:0] tr_rpnt [0:63];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Segment config: ofs/size are table indices (integer pointer), step = 1.
    task automatic cfg(input int s, input int ofs, input int size, input logic [DW-1:0] amp,
                       input logic [DW-1:0] dc, input int ncyc, input int nxt, input bit last);
        set_ofs [s*PW +: PW] = PW'(ofs << 16);
        set_size[s*PW +: PW] = PW'(size << 16);
        set_step[s*PW +: PW] = PW'(32'h1_0000);
        set_amp [s*DW +: DW] = amp;
        set_dc  [s*DW +: DW] = dc;
        set_ncyc[s*16 +: 16] = 16'(ncyc);
        set_next[s*SW +: SW] = SW'(nxt);
        set_last[s]          = last;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        bif.buf_we_i = 1'b1; bif.buf_addr_i = RSZ'(a); bif.buf_wdata_i = d;
        step();
        bif.buf_we_i = 1'b0;
    endtask

    // Pulse the sw trigger and trace n cycles. Cycle c is sampled after the
    // c-th edge following the pulse; RUN is entered at c=2 and the first
    // sample of the run reaches dac_o at c=8, where scoreboard popping starts.
    task automatic run(input int n, output int ndone);
        ndone = 0;
        trig_sw = 1'b1;
        for (int c = 1; c <= n; c++) begin
            step();
            if (c == 1) trig_sw = 1'b0;
            tr_done[c] = done; tr_busy[c] = busy; tr_seg[c] = seg_o; tr_rpnt[c] = rpnt;
            ndone += int'(done);
            if (c >= 8 && q.size() > 0) chk("dac", 32'(dac_o), 32'(q.pop_front()));
        end
        chk("sb_drained", q.size(), 0);
    endtask

    function automatic void push(input logic [DW-1:0] v[]);
        foreach (v[i]) q.push_back(v[i]);
    endfunction

    initial begin
        int nd, bz;
        bif.buf_we_i = 1'b0; bif.buf_addr_i = '0; bif.buf_wdata_i = '0;
        step(); step();
        chk("rst_dac", 32'(dac_o), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_seg", 32'(seg_o), 0);
        chk("rst_rpnt", 32'(rpnt), 0);
        rstn = 1'b1;
        step();
        for (int i = 0; i < 16; i++) wr(i, DW'(i));

        // single segment, two periods, stop on last
        cfg(0, 0, 3, 14'h2000, 14'h0, 2, 1, 1);
        push('{0, 1, 2, 3, 0, 1, 2, 3, 3});
        run(16, nd);
        chk("t1_done_cnt", nd, 1);
        chk("t1_done_at", 32'(tr_done[10]), 1);
        chk("t1_busy_run", 32'(tr_busy[9]), 1);
        chk("t1_busy_fall", 32'(tr_busy[10]), 0);
        chk("t1_rpnt", 32'(tr_rpnt[4]), 2);
        step(); step();
        chk("t1_hold", 32'(dac_o), 3);

        // 0 -> 1 -> 2, no gap; seg 1 half amplitude, seg 2 offset 100
        cfg(0, 0, 3, 14'h2000, 14'h0, 1, 1, 0);
        cfg(1, 4, 6, 14'h1000, 14'h0, 1, 2, 0);
        cfg(2, 8, 9, 14'h2000, 14'd100, 1, 0, 1);
        push('{0, 1, 2, 3, 2, 2, 3, 108, 109, 109});
        run(17, nd);
        chk("t2_done_cnt", nd, 1);
        chk("t2_done_at", 32'(tr_done[11]), 1);
        chk("t2_seg0", 32'(tr_seg[5]), 0);
        chk("t2_seg1", 32'(tr_seg[6]), 1);
        chk("t2_seg2", 32'(tr_seg[9]), 2);

        // same with a 5-cycle gap: last sample of each segment held 5 extra cycles
        set_gap = 32'd5;
        push('{0, 1, 2, 3, 3, 3, 3, 3, 3, 2, 2, 3, 3, 3, 3, 3, 3, 108, 109, 109});
        run(27, nd);
        chk("t3_done_cnt", nd, 1);
        chk("t3_done_at", 32'(tr_done[21]), 1);
        chk("t3_busy_gap", 32'(tr_busy[8]), 1);
        chk("t3_busy_end", 32'(tr_busy[20]), 1);
        chk("t3_seg_gap", 32'(tr_seg[10]), 0);
        chk("t3_seg_next", 32'(tr_seg[11]), 1);
        chk("t3_rpnt_frz", 32'(tr_rpnt[10]), 3);
        chk("t3_rpnt_next", 32'(tr_rpnt[11]), 4);

        // saturation both ways
        set_gap = 32'd0;
        wr(0, 14'h1FFF);
        wr(1, 14'h2000);
        cfg(0, 0, 0, 14'h3FFF, 14'h1000, 1, 1, 0);
        cfg(1, 1, 1, 14'h3FFF, 14'h3000, 1, 0, 1);
        push('{14'h1FFF, 14'h2000, 14'h2000});
        run(10, nd);
        chk("t4_done_at", 32'(tr_done[4]), 1);
        set_zero = 1'b1;
        step();
        chk("zero_on", 32'(dac_o), 0);
        set_zero = 1'b0;
        step();
        chk("zero_off", 32'(dac_o), 32'h2000);

        // endless loop on seg 0 via ext trigger, aborted by set_rst + trig
        cfg(0, 0, 3, 14'h2000, 14'h0, 0, 0, 0);
        trig_src = 2'd2;
        trig_ext = 1'b1;
        step();
        trig_ext = 1'b0;
        repeat (8) step();
        chk("t5_busy", 32'(busy), 1);
        chk("t5_seg", 32'(seg_o), 0);
        set_first = 2'd2;
        trig_src = 2'd3;
        set_rst = 1'b1; trig_sw = 1'b1;
        step();
        set_rst = 1'b0; trig_sw = 1'b0;
        chk("t5_rst_rpnt", 32'(rpnt), 8);
        nd = 0; bz = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            nd += int'(done);
            bz += int'(busy);
        end
        chk("t5_no_done", nd, 0);
        chk("t5_idle", bz, 0);
        push('{108, 109, 109});
        run(10, nd);
        chk("t5_restart_seg", 32'(tr_seg[2]), 2);
        chk("t5_done_at", 32'(tr_done[4]), 1);
        chk("t5_done_cnt", nd, 1);

        // async reset between edges
        #3 rstn = 1'b0;
        #1;
        chk("ar_dac", 32'(dac_o), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_seg", 32'(seg_o), 0);
        chk("ar_rpnt", 32'(rpnt), 0);
        chk("ar_done", 32'(done), 0);
        rstn = 1'b1;
        step();
        bif.buf_addr_i = RSZ'(5);
        step();
        chk("rb_5", 32'(bif.buf_rdata_o), 5);
        bif.buf_addr_i = RSZ'(0);
        step();
        chk("rb_0", 32'(bif.buf_rdata_o), 32'h1FFF);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
